// File: rtl/regfile_pkg.sv
// Shared defaults and index/data types for the integer register file.
package regfile_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_XLEN-1:0] xlen_t;
  typedef logic [RF_AW-1:0]   reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered popcount.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  output logic [NREGS-1:0]  busy,
  output logic [AW:0]       busy_cnt
);

  logic [NREGS-1:0] busy_d, busy_q;
  logic [AW:0]      cnt_d, cnt_q;

  // Write-back clears first so that a same-cycle issue to the same register re-arms it.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
        busy_d[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (issue_en && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (rst) begin
      busy_d = '0;
    end
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
    cnt_q  <= cnt_d;
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/register_unit_mp.sv
// Multi-port integer register file with optional same-cycle write bypass and
// a pending-write scoreboard for decode hazard detection.
module register_unit_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NRD*AW-1:0]   RuRdAddr,
  output logic [NRD*XLEN-1:0] RuRdData,
  output logic [NRD-1:0]      RuRdBusy,
  input  logic [NWR-1:0]      RuWrEn,
  input  logic [NWR*AW-1:0]   RuWrAddr,
  input  logic [NWR*XLEN-1:0] RuWrData,
  input  logic                RuIssueEn,
  input  logic [AW-1:0]       RuIssueRd,
  output logic [AW:0]         RuBusyCnt
);

  logic [XLEN-1:0]  regs_d [NREGS];
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_vec;

  // Ports are applied in ascending order so the highest-indexed writer wins.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++) begin
      if (RuWrEn[p] && RuWrAddr[p*AW +: AW] != '0) begin
        regs_d[RuWrAddr[p*AW +: AW]] = RuWrData[p*XLEN +: XLEN];
      end
    end
    if (Rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_d[r] = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    regs_q <= regs_d;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (Rst),
    .wr_en    (RuWrEn),
    .wr_addr  (RuWrAddr),
    .issue_en (RuIssueEn),
    .issue_rd (RuIssueRd),
    .busy     (busy_vec),
    .busy_cnt (RuBusyCnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   idx;
    logic            hit;
    logic [XLEN-1:0] byp_data;
    logic [XLEN-1:0] data;
    logic            busy;

    assign idx = RuRdAddr[i*AW +: AW];

    // A forwarded write retires the producer, so busy only survives a same-cycle re-issue.
    always_comb begin
      hit      = 1'b0;
      byp_data = '0;
      for (int p = 0; p < NWR; p++) begin
        if (RuWrEn[p] && RuWrAddr[p*AW +: AW] == idx) begin
          hit      = 1'b1;
          byp_data = RuWrData[p*XLEN +: XLEN];
        end
      end
      data = regs_q[idx];
      busy = busy_vec[idx];
      if (idx == '0) begin
        data = '0;
        busy = 1'b0;
      end else if (BYPASS != 0 && !Rst && hit) begin
        data = byp_data;
        busy = RuIssueEn && (RuIssueRd == idx);
      end
    end

    assign RuRdData[i*XLEN +: XLEN] = data;
    assign RuRdBusy[i]              = busy;
  end

endmodule

// File: tb/tb_register_unit_mp.sv
// Bench for register_unit_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_register_unit_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;

  logic [NRD*XLEN-1:0] d1_data, d0_data;
  logic [NRD-1:0]      d1_busy, d0_busy;
  logic [AW:0]         d1_cnt, d0_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] mem [NREGS];
  bit              busyv [NREGS];

  always #5 clk = ~clk;

  register_unit_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
    .Clk(clk), .Rst(rst), .RuRdAddr(rd_addr), .RuRdData(d1_data), .RuRdBusy(d1_busy),
    .RuWrEn(wr_en), .RuWrAddr(wr_addr), .RuWrData(wr_data),
    .RuIssueEn(issue_en), .RuIssueRd(issue_rd), .RuBusyCnt(d1_cnt)
  );

  register_unit_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nobyp (
    .Clk(clk), .Rst(rst), .RuRdAddr(rd_addr), .RuRdData(d0_data), .RuRdBusy(d0_busy),
    .RuWrEn(wr_en), .RuWrAddr(wr_addr), .RuWrData(wr_data),
    .RuIssueEn(issue_en), .RuIssueRd(issue_rd), .RuBusyCnt(d0_cnt)
  );

  // Reference model: architectural state plus the read rules applied to the current inputs.
  function automatic logic [XLEN-1:0] m_data(input int bp, input int port);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    a = rd_addr[port*AW +: AW];
    if (a == 0) return '0;
    d = mem[a];
    if (bp != 0 && !rst)
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) d = wr_data[p*XLEN +: XLEN];
    return d;
  endfunction

  function automatic logic m_busy(input int bp, input int port);
    logic [AW-1:0] a;
    a = rd_addr[port*AW +: AW];
    if (a == 0) return 1'b0;
    if (bp != 0 && !rst)
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) return issue_en && issue_rd == a;
    return busyv[a];
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(busyv[r]);
    return c;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] = '0;
        busyv[r] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] != 0) begin
          mem[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
          busyv[wr_addr[p*AW +: AW]] = 1'b0;
        end
      end
      if (issue_en && issue_rd != 0) busyv[issue_rd] = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    idle(); rd_addr = {5'd5, 5'd5}; #1;
    vectors++; if (d1_cnt !== 0 || d0_cnt !== 0) begin miscompares++;
      $display("FAIL init_cnt: got %0d/%0d expected 0", d1_cnt, d0_cnt); end
    set_wr(0, 5, 32'hDEADBEEF); issue_en = 1'b1; issue_rd = 5'd6; tick();
    idle(); rd_addr = {5'd5, 5'd5}; #1;
    vectors++; if (d0_data[31:0] !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL pre_reset_x5: got %h expected deadbeef", d0_data[31:0]); end
    rst = 1'b1; tick(); idle(); rd_addr = {5'd6, 5'd5}; #1;
    vectors++; if (d1_data[31:0] !== 0 || d0_data[31:0] !== 0) begin miscompares++;
      $display("FAIL reset_x5: got %h/%h expected 0", d1_data[31:0], d0_data[31:0]); end
    vectors++; if (d1_busy !== 2'b00 || d0_busy !== 2'b00) begin miscompares++;
      $display("FAIL reset_busy: got %b/%b expected 00", d1_busy, d0_busy); end
    vectors++; if (d1_cnt !== 0 || d0_cnt !== 0) begin miscompares++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0", d1_cnt, d0_cnt); end
  endtask

  task automatic test_x0();
    int cnt_before;
    cnt_before = m_cnt();
    idle(); set_wr(0, 0, 32'h1234); issue_en = 1'b1; issue_rd = '0; #1;
    vectors++; if (d1_data !== '0 || d0_data !== '0) begin miscompares++;
      $display("FAIL x0_same_cycle: got %h/%h expected 0", d1_data, d0_data); end
    vectors++; if (d1_busy !== 2'b00) begin miscompares++;
      $display("FAIL x0_busy_same: got %b expected 00", d1_busy); end
    tick(); idle(); #1;
    vectors++; if (d1_data !== '0 || d0_data !== '0 || d0_busy !== 2'b00) begin miscompares++;
      $display("FAIL x0_after: got %h/%h busy %b expected 0", d1_data, d0_data, d0_busy); end
    vectors++; if (d1_cnt !== (AW+1)'(cnt_before)) begin miscompares++;
      $display("FAIL x0_cnt: got %0d expected %0d", d1_cnt, cnt_before); end
  endtask

  task automatic test_dual_write();
    idle(); set_wr(0, 7, 32'hAAAA); set_wr(1, 7, 32'h5555); rd_addr = {5'd7, 5'd7}; #1;
    vectors++; if (d1_data[31:0] !== 32'h5555) begin miscompares++;
      $display("FAIL dual_bypass: got %h expected 5555", d1_data[31:0]); end
    vectors++; if (d0_data[31:0] !== 32'h0) begin miscompares++;
      $display("FAIL dual_nobypass_old: got %h expected 0", d0_data[31:0]); end
    tick(); idle(); rd_addr = {5'd7, 5'd7}; #1;
    vectors++; if (d1_data[63:32] !== 32'h5555 || d0_data[63:32] !== 32'h5555) begin miscompares++;
      $display("FAIL dual_after: got %h/%h expected 5555", d1_data[63:32], d0_data[63:32]); end
  endtask

  task automatic test_bypass();
    idle(); set_wr(1, 3, 32'h1111); tick();
    idle(); set_wr(0, 3, 32'hCAFE); rd_addr = {5'd3, 5'd3}; #1;
    for (int k = 0; k < NRD; k++) begin
      vectors++; if (d1_data[k*XLEN +: XLEN] !== 32'hCAFE) begin miscompares++;
        $display("FAIL bypass_port%0d: got %h expected cafe", k, d1_data[k*XLEN +: XLEN]); end
      vectors++; if (d0_data[k*XLEN +: XLEN] !== 32'h1111) begin miscompares++;
        $display("FAIL nobypass_port%0d: got %h expected 1111", k, d0_data[k*XLEN +: XLEN]); end
    end
    tick(); idle(); rd_addr = {5'd3, 5'd3}; #1;
    vectors++; if (d0_data !== {2{32'hCAFE}}) begin miscompares++;
      $display("FAIL nobypass_next: got %h expected cafe x2", d0_data); end
  endtask

  task automatic test_scoreboard();
    idle(); issue_en = 1'b1; issue_rd = 5'd9; tick();
    idle(); rd_addr = {5'd0, 5'd9}; #1;
    vectors++; if (d1_busy !== 2'b01 || d0_busy !== 2'b01) begin miscompares++;
      $display("FAIL sb_issue_busy: got %b/%b expected 01", d1_busy, d0_busy); end
    vectors++; if (d1_cnt !== 1) begin miscompares++;
      $display("FAIL sb_issue_cnt: got %0d expected 1", d1_cnt); end
    set_wr(1, 9, 32'h99); #1;
    vectors++; if (d1_busy[0] !== 1'b0 || d0_busy[0] !== 1'b1) begin miscompares++;
      $display("FAIL sb_wb_same: got %b/%b expected 0/1", d1_busy[0], d0_busy[0]); end
    tick(); idle(); rd_addr = {5'd9, 5'd9}; #1;
    vectors++; if (d0_busy !== 2'b00 || d1_cnt !== 0) begin miscompares++;
      $display("FAIL sb_wb_clear: got busy %b cnt %0d expected 00/0", d0_busy, d1_cnt); end
    issue_en = 1'b1; issue_rd = 5'd9; set_wr(0, 9, 32'h9A); #1;
    vectors++; if (d1_busy !== 2'b11) begin miscompares++;
      $display("FAIL sb_reissue_byp: got %b expected 11", d1_busy); end
    tick(); idle(); rd_addr = {5'd9, 5'd9}; #1;
    vectors++; if (d0_busy !== 2'b11 || d1_cnt !== 1) begin miscompares++;
      $display("FAIL sb_issue_wins: got busy %b cnt %0d expected 11/1", d0_busy, d1_cnt); end
    set_wr(0, 9, 32'h9B); tick(); idle();
  endtask

  task automatic test_reset_midflight();
    for (int r = 1; r <= 3; r++) begin
      idle(); issue_en = 1'b1; issue_rd = AW'(r); tick();
    end
    idle(); #1;
    vectors++; if (d1_cnt !== 3 || d0_cnt !== 3) begin miscompares++;
      $display("FAIL mid_cnt3: got %0d/%0d expected 3", d1_cnt, d0_cnt); end
    rst = 1'b1; set_wr(0, 1, 32'h77); rd_addr = {5'd1, 5'd1}; #1;
    vectors++; if (d1_data[31:0] !== 32'h0 || d1_busy !== 2'b11) begin miscompares++;
      $display("FAIL mid_rst_nobypass: got %h busy %b expected 0/11", d1_data[31:0], d1_busy); end
    tick(); idle(); rd_addr = {5'd2, 5'd1}; #1;
    vectors++; if (d1_cnt !== 0 || d0_cnt !== 0) begin miscompares++;
      $display("FAIL mid_cnt0: got %0d/%0d expected 0", d1_cnt, d0_cnt); end
    vectors++; if (d0_data[31:0] !== 0 || d0_busy !== 2'b00) begin miscompares++;
      $display("FAIL mid_x1: got %h busy %b expected 0/00", d0_data[31:0], d0_busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, int'($urandom_range(0, 7)), $urandom);
      issue_en = ($urandom_range(0, 2) != 0);
      issue_rd = AW'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < NRD; k++) begin
        vectors++; if (d1_data[k*XLEN +: XLEN] !== m_data(1, k) || d1_busy[k] !== m_busy(1, k)) begin
          miscompares++;
          $display("FAIL rand_byp_port%0d: got %h/%b expected %h/%b", k,
                   d1_data[k*XLEN +: XLEN], d1_busy[k], m_data(1, k), m_busy(1, k)); end
        vectors++; if (d0_data[k*XLEN +: XLEN] !== m_data(0, k) || d0_busy[k] !== m_busy(0, k)) begin
          miscompares++;
          $display("FAIL rand_nobyp_port%0d: got %h/%b expected %h/%b", k,
                   d0_data[k*XLEN +: XLEN], d0_busy[k], m_data(0, k), m_busy(0, k)); end
      end
      vectors++; if (d1_cnt !== (AW+1)'(m_cnt()) || d0_cnt !== (AW+1)'(m_cnt())) begin miscompares++;
        $display("FAIL rand_cnt: got %0d/%0d expected %0d", d1_cnt, d0_cnt, m_cnt()); end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_x0();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
